dadda_mul_arbiter: RTL

- Shares one combinational WIDTH x WIDTH signed Dadda multiplier core among NREQ requesters.
- Arbitrates with a round-robin pointer and captures the winner's operands into a register.
- Multiplies over one registered cycle and holds the tagged product on a valid/ready result port until it is consumed.
- Sits between the operand-issuing clients and the downstream consumer of products in the high-speed arithmetic datapath.

---
 rtl/dadda_pkg.sv | 24 ++
 rtl/dadda_mul_core.sv | 96 +++++++++
 rtl/dadda_mul_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/dadda_pkg.sv
// dadda_pkg: shared constants, FSM states and the Dadda height
// helper for the shared signed multiplier arbiter.
package dadda_pkg;

    localparam int WIDTH_DEF = 6;
    localparam int NREQ_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Dadda stage height limits: 2, 3, 4, 6, 9, 13, 19, ...
    function automatic int dadda_height(input int k);
        int d;
        d = 2;
        for (int i = 0; i < k; i++) begin
            d = (d * 3) / 2;
        end
        return d;
    endfunction

endpackage

// File: rtl/dadda_mul_core.sv
// dadda_mul_core: combinational signed WIDTH x WIDTH multiplier.
// Baugh-Wooley partial products, Dadda column reduction, final CPA.
module dadda_mul_core
    import dadda_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);

    localparam int P = 2 * WIDTH;
    localparam int H = 2 * WIDTH + 2;

    logic [H-1:0] col [P];
    int           ht  [P];
    logic [P-1:0] row0;
    logic [P-1:0] row1;
    logic         pp;
    logic         x;
    logic         y;
    logic         z;
    logic         carry;
    int           d;

    // Build the bit matrix, reduce each column to two bits, then add.
    always_comb begin
        for (int c = 0; c < P; c++) begin
            col[c] = '0;
            ht[c]  = 0;
        end
        pp    = 1'b0;
        x     = 1'b0;
        y     = 1'b0;
        z     = 1'b0;
        carry = 1'b0;
        d     = 2;
        row0  = '0;
        row1  = '0;

        // Cross terms with exactly one sign bit enter inverted; the
        // two constant ones below restore the signed weighting.
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp = a[j] & b[i];
                if ((i == WIDTH - 1) != (j == WIDTH - 1)) begin
                    pp = ~pp;
                end
                col[i+j][ht[i+j]] = pp;
                ht[i+j] = ht[i+j] + 1;
            end
        end
        col[WIDTH][ht[WIDTH]] = 1'b1;
        ht[WIDTH] = ht[WIDTH] + 1;
        col[P-1][ht[P-1]] = 1'b1;
        ht[P-1] = ht[P-1] + 1;

        // Each stage squeezes every column down to the stage limit.
        for (int s = 8; s >= 0; s--) begin
            d = dadda_height(s);
            for (int c = 0; c < P; c++) begin
                for (int k = 0; k < H; k++) begin
                    if (ht[c] > d) begin
                        if (ht[c] == d + 1) begin
                            x = col[c][ht[c]-1];
                            y = col[c][ht[c]-2];
                            ht[c] = ht[c] - 2;
                            col[c][ht[c]] = x ^ y;
                            carry = x & y;
                        end else begin
                            x = col[c][ht[c]-1];
                            y = col[c][ht[c]-2];
                            z = col[c][ht[c]-3];
                            ht[c] = ht[c] - 3;
                            col[c][ht[c]] = x ^ y ^ z;
                            carry = (x & y) | (x & z) | (y & z);
                        end
                        ht[c] = ht[c] + 1;
                        if (c + 1 < P) begin
                            col[c+1][ht[c+1]] = carry;
                            ht[c+1] = ht[c+1] + 1;
                        end
                    end
                end
            end
        end

        for (int c = 0; c < P; c++) begin
            row0[c] = (ht[c] > 0) ? col[c][0] : 1'b0;
            row1[c] = (ht[c] > 1) ? col[c][1] : 1'b0;
        end
        p = row0 + row1;
    end

endmodule

// File: rtl/dadda_mul_arbiter.sv
// dadda_mul_arbiter: round-robin share of one Dadda multiplier.
// Define DADDA_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration.
module dadda_mul_arbiter
    import dadda_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREQ  = NREQ_DEF,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [2*WIDTH-1:0]    res_data,
    output logic [IDW-1:0]        res_id,
    output logic                  busy
);

    state_t             state;
    state_t             state_nx;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [IDW-1:0]     op_id;
    logic [2*WIDTH-1:0] prod;
    logic               grant_hit;
    logic [IDW-1:0]     grant_id;
    int                 idx;
    logic               take;

`ifndef DADDA_ARB_FIXED_PRIO_EN
    logic [IDW-1:0]     rr_ptr;
`endif

    dadda_mul_core #(.WIDTH(WIDTH)) u_core (
        .a(op_a),
        .b(op_b),
        .p(prod)
    );

    // Pick the first requester at or after the search start.
    always_comb begin
        grant_hit = 1'b0;
        grant_id  = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef DADDA_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (int'(rr_ptr) + k) % NREQ;
`endif
            if (!grant_hit && req_valid[idx]) begin
                grant_hit = 1'b1;
                grant_id  = IDW'(idx);
            end
        end
    end

    assign take = (state == IDLE) && grant_hit;
    assign busy = (state != IDLE);

    // One-hot grant, offered only while idle.
    always_comb begin
        req_ready = '0;
        if (take) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (grant_hit) state_nx = CALC;
            CALC:    state_nx = HOLD;
            HOLD:    if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

`ifndef DADDA_ARB_FIXED_PRIO_EN
    // Search start moves past each winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (take) begin
            rr_ptr <= IDW'((int'(grant_id) + 1) % NREQ);
        end
    end
`endif

    // Operand capture and result holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
        end else begin
            if (take) begin
                op_a  <= req_a[int'(grant_id)*WIDTH +: WIDTH];
                op_b  <= req_b[int'(grant_id)*WIDTH +: WIDTH];
                op_id <= grant_id;
            end
            if (state == CALC) begin
                res_data  <= prod;
                res_id    <= op_id;
                res_valid <= 1'b1;
            end
            if (state == HOLD && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule
